interconnect_tagging_arbiter: RTL



---
 rtl/interconnect_tagging_arbiter.sv | 109 ++++++++++
 1 files changed

// File: rtl/interconnect_tagging_arbiter.sv
// interconnect_tagging_arbiter
//   Merges N_INPUTS val/rdy source streams into one tagged return stream.
//   Each accepted word is stored as {source index, payload} in a 2-entry FIFO
//   whose head drives send_msg straight from a register.
//   Optional feature macro: ARB_ROUND_ROBIN_EN
//     defined   -> round-robin priority search starting at grant pointer gp
//     undefined -> fixed priority, lowest index wins (no grant pointer)
//   Handshake: a word moves on any cycle where val and rdy are both high.
//   A source must hold val and msg stable until it sees rdy.
//   recv_rdy is asserted only for the granted source.
module interconnect_tagging_arbiter #(
  parameter int BIT_WIDTH = 32,
  parameter int N_INPUTS  = 16,
  parameter int ADDR_BITS = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [N_INPUTS-1:0]            recv_val,
  output logic [N_INPUTS-1:0]            recv_rdy,
  input  logic [BIT_WIDTH-1:0]           recv_msg [N_INPUTS],
  output logic                           send_val,
  input  logic                           send_rdy,
  output logic [BIT_WIDTH+ADDR_BITS-1:0] send_msg
);

  localparam int MW = BIT_WIDTH + ADDR_BITS;

  logic [MW-1:0]        r_mem [2];
  logic                 r_head;
  logic                 r_tail;
  logic [1:0]           r_count;

  logic [ADDR_BITS-1:0] w_grant;
  logic                 w_grant_vld;
  logic                 w_space;
  logic                 w_fire;
  logic                 w_deq;
  int                   w_idx;

`ifdef ARB_ROUND_ROBIN_EN
  logic [ADDR_BITS-1:0] r_gp;
  logic [ADDR_BITS-1:0] w_gp_next;
`endif

  // Priority search for the first valid source (from gp, or from 0 in fixed mode)
  always_comb begin
    w_grant     = '0;
    w_grant_vld = 1'b0;
    w_idx       = 0;
    for (int i = 0; i < N_INPUTS; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
      w_idx = int'(r_gp) + i;
      if (w_idx >= N_INPUTS) w_idx = w_idx - N_INPUTS;
`else
      w_idx = i;
`endif
      if (!w_grant_vld && recv_val[w_idx]) begin
        w_grant_vld = 1'b1;
        w_grant     = ADDR_BITS'(w_idx);
      end
    end
  end

  // Space exists when not full, or full but the head leaves this cycle
  assign w_space  = (r_count != 2'd2) || send_rdy;
  assign w_fire   = w_grant_vld && w_space && !reset;
  assign send_val = (r_count != 2'd0) && !reset;
  assign w_deq    = send_val && send_rdy;
  assign send_msg = r_mem[r_head];

  // One-hot ready towards the granted source only
  always_comb begin
    recv_rdy = '0;
    if (w_fire) recv_rdy[w_grant] = 1'b1;
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Next search start is one past the last winner, wrapping at N_INPUTS
  always_comb begin
    w_gp_next = '0;
    if (int'(w_grant) + 1 < N_INPUTS) w_gp_next = w_grant + 1'b1;
  end

  // Grant pointer advances only when a word is accepted
  always_ff @(posedge clk) begin
    if (reset)       r_gp <= '0;
    else if (w_fire) r_gp <= w_gp_next;
  end
`endif

  // Tagged-word FIFO: enqueue at tail, dequeue at head, count tracks occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_head   <= 1'b0;
      r_tail   <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_fire) begin
        r_mem[r_tail] <= {w_grant, recv_msg[w_grant]};
        r_tail        <= ~r_tail;
      end
      if (w_deq) r_head <= ~r_head;
      r_count <= r_count + {1'b0, w_fire} - {1'b0, w_deq};
    end
  end

endmodule
